// File: rtl/mem_latency_model_if.sv
// Request/response bundle for mem_latency_model: one slice per channel in each
// flattened vector.
interface mem_latency_model_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 4
);
    logic [NCH-1:0]        Mout_oe_ram;
    logic [NCH-1:0]        Mout_we_ram;
    logic [NCH*ADDR_W-1:0] Mout_addr_ram;
    logic [NCH*DATA_W-1:0] Mout_Wdata_ram;
    logic [NCH*SIZE_W-1:0] Mout_data_ram_size;
    logic [NCH*DATA_W-1:0] M_Rdata_ram;
    logic [NCH-1:0]        M_DataRdy;
    logic [NCH-1:0]        busy;
    logic [NCH-1:0]        err_conflict;

    modport master (
        output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        input  M_Rdata_ram, M_DataRdy, busy, err_conflict
    );

    modport slave (
        input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
        output M_Rdata_ram, M_DataRdy, busy, err_conflict
    );
endinterface

// File: rtl/mem_latency_model.sv
// Multi-channel memory window with per-channel fixed read/write latency.
// Each channel owns a small counter FSM; the storage array is shared, with
// same-edge write merging by mask (highest channel wins on overlapping bits).

// Per-channel latency sequencer: decides when a held request completes.
module mem_latency_ch #(
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic oe,
    input  logic we,
    input  logic in_win,
    output logic rdy,
    output logic busy,
    output logic err_conflict,
    output logic cur_rd
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [4:0] RD_LAST = 5'(RD_LAT - 1);
    localparam logic [4:0] WR_LAST = 5'(WR_LAT - 1);

    state_t     state, state_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic       is_rd, is_rd_nxt;
    logic       rd_req, wr_req, held;
    logic [4:0] last;

    // A conflicting oe+we pair qualifies as neither kind, which aborts WAIT.
    assign rd_req = oe & ~we & in_win;
    assign wr_req = we & ~oe & in_win;
    // In IDLE the kind comes from the live request; in WAIT from the one that started.
    assign cur_rd = (state == WAIT) ? is_rd : rd_req;
    assign held   = is_rd ? rd_req : wr_req;
    assign last   = cur_rd ? RD_LAST : WR_LAST;

    // Next-state, completion strobe and busy; requests are ignored during reset.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        is_rd_nxt = is_rd;
        rdy       = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        busy = 1'b1;
                        if (last == 5'd0) begin
                            rdy = 1'b1;
                        end else begin
                            state_nxt = WAIT;
                            cnt_nxt   = 5'd1;
                            is_rd_nxt = rd_req;
                        end
                    end
                end
                WAIT: begin
                    if (!held) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 5'd0;
                    end else begin
                        busy = 1'b1;
                        if (cnt == last) begin
                            rdy       = 1'b1;
                            state_nxt = IDLE;
                            cnt_nxt   = 5'd0;
                        end else begin
                            cnt_nxt = cnt + 5'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register plus sticky conflict flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 5'd0;
            is_rd        <= 1'b0;
            err_conflict <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            is_rd <= is_rd_nxt;
            if (oe && we) err_conflict <= 1'b1;
        end
    end
endmodule

module mem_latency_model #(
    parameter int NCH       = 2,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 8,
    parameter int SIZE_W    = 4,
    parameter int MEMSIZE   = 256,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 2,
    parameter int WR_LAT    = 1
) (
    input logic clock,
    input logic reset,
    mem_latency_model_if.slave bus
);
    localparam int IDX_W = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

    logic [NCH-1:0]             in_win, rdy, busy_v, err_v, cur_rd, rd_en, wr_en;
    logic [NCH-1:0][IDX_W-1:0]  idx;
    logic [NCH-1:0][DATA_W-1:0] wdata, mask, rdata;
    logic [DATA_W-1:0]          mem     [MEMSIZE];
    logic [DATA_W-1:0]          mem_nxt [MEMSIZE];

    // Unpack channel slices: window hit, storage index, write data and size mask.
    always_comb begin
        in_win = '0;
        idx    = '0;
        wdata  = '0;
        mask   = '0;
        for (int c = 0; c < NCH; c++) begin
            // Wide subtraction so addresses below the base wrap far above MEMSIZE.
            in_win[c] = (33'(bus.Mout_addr_ram[c*ADDR_W +: ADDR_W]) - 33'(BASE_ADDR)) < 33'(MEMSIZE);
            idx[c]    = IDX_W'(bus.Mout_addr_ram[c*ADDR_W +: ADDR_W] - ADDR_W'(BASE_ADDR));
            wdata[c]  = bus.Mout_Wdata_ram[c*DATA_W +: DATA_W];
            for (int b = 0; b < DATA_W; b++)
                mask[c][b] = 32'(bus.Mout_data_ram_size[c*SIZE_W +: SIZE_W]) > b;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        mem_latency_ch #(
            .RD_LAT (RD_LAT),
            .WR_LAT (WR_LAT)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .oe           (bus.Mout_oe_ram[i]),
            .we           (bus.Mout_we_ram[i]),
            .in_win       (in_win[i]),
            .rdy          (rdy[i]),
            .busy         (busy_v[i]),
            .err_conflict (err_v[i]),
            .cur_rd       (cur_rd[i])
        );
    end

    // Read data comes from the pre-edge array, so a same-cycle write is not visible.
    always_comb begin
        rd_en = rdy & cur_rd;
        wr_en = rdy & ~cur_rd;
        rdata = '0;
        for (int c = 0; c < NCH; c++)
            rdata[c] = rd_en[c] ? mem[idx[c]] : '0;
    end

    // Merge all completing writes in channel order so higher channels override.
    always_comb begin
        mem_nxt = mem;
        for (int c = 0; c < NCH; c++)
            if (wr_en[c])
                mem_nxt[idx[c]] = (wdata[c] & mask[c]) | (mem_nxt[idx[c]] & ~mask[c]);
    end

    // Storage update; reset clears every word and drops pending writes.
    always_ff @(posedge clock) begin
        for (int j = 0; j < MEMSIZE; j++)
            mem[j] <= reset ? '0 : mem_nxt[j];
    end

    assign bus.M_DataRdy    = rdy;
    assign bus.busy         = busy_v;
    assign bus.err_conflict = err_v;
    assign bus.M_Rdata_ram  = rdata;
endmodule

// File: doc/mem_latency_model.md
MEM_LATENCY_MODEL -- requirements
Module: mem_latency_model

Interface
REQ-001 SHALL have parameter NCH, default 2, number of independent memory channels.
REQ-002 SHALL have parameter ADDR_W, default 9, per-channel address width.
REQ-003 SHALL have parameter DATA_W, default 8, per-channel data width; one word per address.
REQ-004 SHALL have parameter SIZE_W, default 4, per-channel access-size field width.
REQ-005 SHALL have parameter MEMSIZE, default 256, number of words in the window.
REQ-006 SHALL have parameter BASE_ADDR, default 0, first address of the window.
REQ-007 SHALL have parameter RD_LAT, default 2, read latency in cycles; legal range is 1..16.
REQ-008 SHALL have parameter WR_LAT, default 1, write latency in cycles; legal range is 1..16.
REQ-009 SHALL have one clock and a synchronous, active-high reset:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
REQ-010 SHALL have the following request and response ports:
- Mout_oe_ram  in  NCH  per-channel read request.
- Mout_we_ram  in  NCH  per-channel write request.
- Mout_addr_ram  in  NCH*ADDR_W  channel i address in slice [i*ADDR_W +: ADDR_W].
- Mout_Wdata_ram  in  NCH*DATA_W  per-channel write data.
- Mout_data_ram_size  in  NCH*SIZE_W  per-channel access size in bits.
- M_Rdata_ram  out  NCH*DATA_W  per-channel read data.
- M_DataRdy  out  NCH  per-channel completion strobe.
- busy  out  NCH  transaction in flight.
- err_conflict  out  NCH  sticky flag: oe and we seen together.

Function
REQ-011 An address SHALL be in-window iff BASE_ADDR <= addr < BASE_ADDR+MEMSIZE; storage index = addr-BASE_ADDR.
REQ-012 Each channel SHALL run its own counter FSM with states IDLE and WAIT; the counter width SHALL be 5 bits.
REQ-013 Transaction start: cycle k SHALL be the first cycle with exactly one of oe/we high and the address in-window; LAT SHALL be RD_LAT for a read, WR_LAT for a write.
REQ-014 M_DataRdy[i] SHALL be high in cycle k+LAT-1 only; LAT=1 SHALL give a combinational same-cycle response.
REQ-015 busy[i] SHALL be high from cycle k to cycle k+LAT-1 inclusive.
REQ-016 Transitions:
- IDLE->WAIT at the end of cycle k when LAT>1.
- Counter increments each cycle while the request is held.
- WAIT->IDLE at the end of the DataRdy cycle.
REQ-017 Request held past the DataRdy cycle SHALL start a new transaction in the next cycle (back-to-back, no idle gap).
REQ-018 Request (oe/we) dropped before the DataRdy cycle SHALL abort the transaction: FSM to IDLE, counter 0, no write, no DataRdy.
REQ-019 Address, data or size changing mid-transaction SHALL NOT restart the transaction; values present in the DataRdy cycle are used.
REQ-020 Read: during the DataRdy cycle M_Rdata_ram[i] SHALL equal mem[idx] as of the start of that cycle; at all other times it SHALL be 0.
REQ-021 Write commit at the edge ending the DataRdy cycle, with mask = (1<<size)-1 and size>=DATA_W meaning all ones:
- mem[idx] <= (wdata & mask) | (mem[idx] & ~mask).
- size=0 SHALL leave the word unchanged but still complete.
REQ-022 Same-edge commits by several channels to one index SHALL be resolved bitwise per mask, highest channel index winning on overlapping bits.
REQ-023 A read completing in the same cycle as another channel's write commit to the same index SHALL return the pre-write value.
REQ-024 Out-of-window requests SHALL be ignored: no state change, DataRdy 0, Rdata 0, memory untouched.
REQ-025 oe and we both high on a channel SHALL set err_conflict[i] (sticky until reset) and SHALL abort any in-flight transaction on that channel; no access SHALL start that cycle.
REQ-026 Channels SHALL be fully independent except for REQ-022 and REQ-023.

Reset
REQ-027 While reset is high at a rising edge, on that edge:
- all FSMs SHALL go to IDLE with counters at 0.
- busy and err_conflict SHALL be cleared.
- all memory words SHALL be written to 0.
- pending writes SHALL be discarded.
REQ-028 M_DataRdy and M_Rdata_ram SHALL be 0 in the cycle after a reset edge, including when reset lands mid-transaction.
REQ-029 Requests present during a reset cycle SHALL be ignored; a request still held after reset deasserts SHALL start at the first non-reset cycle.

Verification
REQ-030 Defaults, ch0 write addr 5, data 8'hA5, size 8 -> DataRdy[0] in the same cycle; a following read of addr 5 -> DataRdy[0] one cycle after the request, Rdata 8'hA5.
REQ-031 mem[3]=8'hFF, write 8'h00 with size 4 -> mem[3]=8'hF0; write with size 0 -> unchanged, DataRdy still pulses.
REQ-032 RD_LAT=4, read held 10 cycles -> DataRdy pulses in cycles 3 and 7, busy stays continuously high; read dropped after 2 cycles -> no DataRdy, FSM back in IDLE.
REQ-033 Both channels write addr 7 in the same cycle, ch0 8'h0F and ch1 8'hF0 with full masks -> mem[7]=8'hF0; ch0 8'h0F size 8 and ch1 8'hF0 size 4 (mask 8'h0F) -> mem[7]=8'h00.
REQ-034 Address BASE_ADDR+MEMSIZE -> no DataRdy, memory unchanged; oe and we together on ch1 -> err_conflict[1]=1 until reset, ch0 unaffected.
REQ-035 Reset asserted in cycle 1 of a RD_LAT=3 read -> no DataRdy, busy=0 and memory reads 0 afterwards; request held -> new transaction starts after reset.
